rle_run_encoder: RTL and testbench

//  Converts the per-pixel binary mask stream from the colour-threshold stage

---
 rtl/rle_pkg.sv | 31 +++
 rtl/rle_token_fifo.sv | 52 +++++
 rtl/rle_run_encoder.sv | 163 ++++++++++++++++
 tb/tb_rle_run_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: token layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Token layout, MSB first: {last_of_frame, colour, run_len[LEN_W-1:0]}.
package rle_pkg;

  localparam int LEN_W       = 10;
  localparam int TOK_W       = LEN_W + 2;
  localparam int TOK_LAST    = TOK_W - 1;
  localparam int TOK_COL     = TOK_W - 2;
  localparam int TOK_LEN_MSB = LEN_W - 1;

  typedef logic [TOK_W-1:0] tok_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  function automatic tok_t mk_tok(input logic last, input logic col,
                                  input logic [LEN_W-1:0] len);
    tok_t t;
    t                   = '0;
    t[TOK_LAST]         = last;
    t[TOK_COL]          = col;
    t[TOK_LEN_MSB:0]    = len;
    return t;
  endfunction

endpackage

// File: rtl/rle_token_fifo.sv
// Synchronous first-word-fall-through token FIFO.
// Latency: a pushed word is visible on rd_dat_o/ne empty the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high), push_i/wr_dat_i, pop_i, rd_dat_o,
//        full_o, empty_o, free_cnt_o (free slots).
module rle_token_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count;
  logic         do_pop, do_push;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign full_o     = (count == (AW+1)'(DEPTH));
  assign empty_o    = (count == '0);
  assign free_cnt_o = (AW+1)'(DEPTH) - count;
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign do_push    = push_i & (~full_o | do_pop);
  assign rd_dat_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

endmodule

// File: rtl/rle_run_encoder.sv
// Binary mask stream to per-row run-length tokens {last, colour, length}.
// Latency: token written on the edge accepting its closing pixel; tok_valid one cycle later.
// Backpressure: pix_ready drops when the token FIFO is full and for one pending-push cycle.
// Ports: CLK, RST (sync, active-high); pixel in: pix_valid/pix_bit/pix_sof/pix_ready;
//        token out: tok_valid/tok_ready/tok_data; pulses: frame_done, resync_err.
module rle_run_encoder
  import rle_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pix_valid,
  input  logic             pix_bit,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [TOK_W-1:0] tok_data,
  output logic             frame_done,
  output logic             resync_err
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  // x_q is the column of the next pixel to be accepted.
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic             col_q, col_d;
  tok_t             pend_q, pend_d;

  logic             accept, line_end, last_row, same_col;
  logic             push, fifo_full, fifo_empty, pop;
  tok_t             push_tok;
  logic [FW-1:0]    fifo_free;

  assign pix_ready = ~RST & ((state_q == IDLE) | ((state_q == RUN) & (fifo_free != '0)));
  assign accept    = pix_valid & pix_ready;
  assign line_end  = (x_q == XW'(IMG_WIDTH - 1));
  assign last_row  = (y_q == YW'(IMG_HEIGHT - 1));
  // An empty run (start of row) adopts whatever colour arrives.
  assign same_col  = (run_q == '0) | (pix_bit == col_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= '0;
      col_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    col_d   = col_q;
    pend_d  = pend_q;
    if (accept && pix_sof) begin
      // Start of frame, whether expected or a resync: partial work is dropped.
      state_d = RUN;
      col_d   = pix_bit;
      run_d   = LEN_W'(1);
      x_d     = XW'(1);
      y_d     = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (line_end) begin
              x_d   = '0;
              run_d = '0;
              if (!last_row) y_d = y_q + YW'(1);
              if (!same_col) begin
                // Two tokens close on this pixel; the 1-long run waits a cycle.
                pend_d  = mk_tok(last_row, pix_bit, LEN_W'(1));
                state_d = PEND;
              end else if (last_row) begin
                state_d = IDLE;
              end
            end else begin
              x_d   = x_q + XW'(1);
              col_d = pix_bit;
              run_d = same_col ? run_q + LEN_W'(1) : LEN_W'(1);
            end
          end
        end
        PEND: begin
          if (!fifo_full) begin
            state_d = pend_q[TOK_LAST] ? IDLE : RUN;
            run_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    push     = 1'b0;
    push_tok = '0;
    if (!RST) begin
      case (state_q)
        RUN: begin
          if (accept && !pix_sof) begin
            if (line_end) begin
              push     = 1'b1;
              push_tok = same_col ? mk_tok(last_row, pix_bit, run_q + LEN_W'(1))
                                  : mk_tok(1'b0, col_q, run_q);
            end else if (!same_col) begin
              push     = 1'b1;
              push_tok = mk_tok(1'b0, col_q, run_q);
            end
          end
        end
        PEND: begin
          if (!fifo_full) begin
            push     = 1'b1;
            push_tok = pend_q;
          end
        end
        default: ;
      endcase
    end
    frame_done = push & push_tok[TOK_LAST];
    resync_err = accept & pix_sof & (state_q != IDLE);
  end

  assign tok_valid = ~fifo_empty & ~RST;
  assign pop       = tok_valid & tok_ready;

  rle_token_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TOK_W)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push_i     (push),
    .wr_dat_i   (push_tok),
    .pop_i      (pop),
    .rd_dat_o   (tok_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_cnt_o (fifo_free)
  );

endmodule

// File: tb/tb_rle_run_encoder.sv
module tb_rle_run_encoder;
  import rle_pkg::*;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic pix_valid = 1'b0, pix_bit = 1'b0, pix_sof = 1'b0;
  logic pix_ready, tok_valid, tok_ready, frame_done, resync_err;
  logic [TOK_W-1:0] tok_data;
  logic fix_rdy = 1'b1, rnd_mode = 1'b0, rnd_rdy = 1'b1;

  assign tok_ready = rnd_mode ? rnd_rdy : fix_rdy;

  always #5 CLK = ~CLK;

  rle_run_encoder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .pix_valid(pix_valid), .pix_bit(pix_bit), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
    .frame_done(frame_done), .resync_err(resync_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [TOK_W-1:0] exp_q[$];
  logic [TOK_W-1:0] got_q[$];
  bit rowbuf[W];
  int rowlen = 0, row = 0;
  bit in_frame = 0;
  int frames_exp = 0, frames_got = 0, resync_got = 0, low_cnt = 0;

  function automatic logic [TOK_W-1:0] tok(input bit l, input bit c, input int n);
    return {l, c, n[LEN_W-1:0]};
  endfunction

  // Length of the run of equal pixels ending at index e of the current row.
  function automatic int run_back(input int e);
    int n = 1;
    while (e - n >= 0 && rowbuf[e-n] == rowbuf[e]) n++;
    return n;
  endfunction

  task automatic model_pixel(input bit b, input bit s);
    if (s) begin
      rowlen = 0; row = 0; in_frame = 1;
    end else if (!in_frame) begin
      return;
    end
    if (rowlen > 0 && rowbuf[rowlen-1] != b)
      exp_q.push_back(tok(0, rowbuf[rowlen-1], run_back(rowlen-1)));
    rowbuf[rowlen] = b;
    rowlen++;
    if (rowlen == W) begin
      exp_q.push_back(tok(row == H-1, b, run_back(W-1)));
      rowlen = 0;
      if (row == H-1) begin in_frame = 0; frames_exp++; end
      else row++;
    end
  endtask

  // Single compare process, sampling away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      rowlen = 0; row = 0; in_frame = 0;
    end else begin
      if (pix_valid && pix_ready) begin
        check("resync_err", resync_err, pix_sof && in_frame);
        model_pixel(pix_bit, pix_sof);
      end else if (resync_err) begin
        check("resync_err_noacc", resync_err, 0);
      end
      if (resync_err) resync_got++;
      if (!pix_ready) low_cnt++;
      if (frame_done) frames_got++;
      if (tok_valid && tok_ready) begin
        got_q.push_back(tok_data);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tok_unexpected: got 0x%0h expected none at %0t", tok_data, $time);
        end else begin
          check("tok_data", tok_data, exp_q.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    rnd_rdy = ($urandom % 3) != 0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge CLK); #1;
  endtask

  task automatic send(input bit b, input bit s);
    int t = 0;
    pix_valid = 1'b1; pix_bit = b; pix_sof = s;
    @(negedge CLK);
    while (!pix_ready && t < 300) begin t++; @(negedge CLK); end
    if (!pix_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pix_ready stayed 0 for %0d cycles", t);
    end
    @(posedge CLK); #1;
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic send_row(input logic [W-1:0] bits, input bit sof);
    for (int i = 0; i < W; i++) send(bits[W-1-i], sof && i == 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || tok_valid) && t < 500) begin sync(); t++; end
    check("drain_left", exp_q.size(), 0);
    check("frame_done_cnt", frames_got, frames_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0, s0, s1;
    bit stall, prev;
    logic [TOK_W-1:0] d0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_tok_valid", tok_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_resync", resync_err, 0);
    sync(); RST = 1'b0;
    @(negedge CLK);
    check("idle_pix_ready", pix_ready, 1);
    check("idle_tok_valid", tok_valid, 0);
    sync();

    // 1: two rows of ones
    got_q.delete(); f0 = frames_got;
    send_row(8'hFF, 1); send_row(8'hFF, 0);
    drain();
    check("t1_cnt", got_q.size(), 2);
    check("t1_tok0", got_q[0], tok(0, 1, 8));
    check("t1_tok1", got_q[1], tok(1, 1, 8));
    check("t1_frame_done", frames_got - f0, 1);
    @(negedge CLK); check("t1_idle_ready", pix_ready, 1); sync();

    // 2: 11001110 on both rows
    got_q.delete();
    send_row(8'b11001110, 1); send_row(8'b11001110, 0);
    drain();
    check("t2_cnt", got_q.size(), 8);
    check("t2_tok0", got_q[0], tok(0, 1, 2));
    check("t2_tok1", got_q[1], tok(0, 0, 2));
    check("t2_tok2", got_q[2], tok(0, 1, 3));
    check("t2_tok3", got_q[3], tok(0, 0, 1));
    check("t2_tok7", got_q[7], tok(1, 0, 1));
    s0 = 0; s1 = 0;
    for (int i = 0; i < 4; i++) s0 += int'(got_q[i][LEN_W-1:0]);
    for (int i = 4; i < 8; i++) s1 += int'(got_q[i][LEN_W-1:0]);
    check("t2_row0_sum", s0, W);
    check("t2_row1_sum", s1, W);

    // 3: change on the last pixel of a row
    got_q.delete(); low_cnt = 0;
    send_row(8'b00000001, 1); send_row(8'hFF, 0);
    check("t3_ready_low_cycles", low_cnt, 1);
    drain();
    check("t3_tok0", got_q[0], tok(0, 0, 7));
    check("t3_tok1", got_q[1], tok(0, 1, 1));
    check("t3_tok2", got_q[2], tok(1, 1, 8));

    // 4: backpressure fills the FIFO, nothing lost
    got_q.delete(); fix_rdy = 1'b0;
    for (int i = 0; i < 2*W; i++) send(bit'(i % 2), i == 0);
    send(0, 1);
    pix_valid = 1'b1; pix_bit = 1'b1; pix_sof = 1'b0;
    @(negedge CLK); d0 = tok_data; stall = 1;
    for (int i = 0; i < 8; i++) begin
      stall &= !pix_ready;
      @(negedge CLK);
    end
    check("t4_full_stall", stall, 1);
    check("t4_tok_valid", tok_valid, 1);
    check("t4_tok_hold", tok_data, d0);
    sync(); fix_rdy = 1'b1;
    send(1, 0);
    for (int i = 2; i < 2*W; i++) send(bit'(i % 2), 0);
    drain();
    check("t4_cnt", got_q.size(), 32);
    check("t4_first", got_q[0], tok(0, 0, 1));

    // 5: sof at x=5 of row 0
    got_q.delete(); r0 = resync_got;
    send(1, 1); send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    send_row(8'hFF, 1); send_row(8'h00, 0);
    drain();
    check("t5_resync_cnt", resync_got - r0, 1);
    check("t5_cnt", got_q.size(), 3);
    check("t5_tok0", got_q[0], tok(0, 1, 2));
    check("t5_tok1", got_q[1], tok(0, 1, 8));
    check("t5_tok2", got_q[2], tok(1, 0, 8));

    // 6: reset mid-row with tokens queued
    fix_rdy = 1'b0;
    send(1, 1); send(0, 0); send(1, 0);
    @(negedge CLK); check("t6_pre_valid", tok_valid, 1);
    sync(); RST = 1'b1;
    sync();
    @(negedge CLK);
    check("t6_rst_tok_valid", tok_valid, 0);
    check("t6_rst_pix_ready", pix_ready, 0);
    sync(); RST = 1'b0; fix_rdy = 1'b1;
    @(negedge CLK); check("t6_post_ready", pix_ready, 1);
    sync();
    got_q.delete();
    for (int i = 0; i < 5; i++) send(bit'(i % 2), 0);
    repeat (3) sync();
    @(negedge CLK);
    check("t6_dropped_valid", tok_valid, 0);
    check("t6_dropped_cnt", got_q.size(), 0);
    sync();
    f0 = frames_got; frames_exp = frames_got;

    // 7: randomized frames with random consumer stalls and gaps
    rnd_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom % 3) send(bit'($urandom % 2), 0);
      prev = bit'($urandom % 2);
      for (int i = 0; i < 2*W; i++) begin
        if (f % 3 == 0) prev = bit'($urandom % 2);
        else if ($urandom % 4 == 0) prev = ~prev;
        send(prev, i == 0 || ($urandom % 50 == 0));
        if ($urandom % 4 == 0) sync();
      end
      drain();
    end
    rnd_mode = 1'b0;

    check("end_exp_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
